// File: rtl/keyfifo_pkg.sv
`default_nettype none
// ============================================================================
// Package  : keyfifo_pkg
// Brief    : Shared constants for the keycode event FIFO and its ms timer.
// Revision : 1.0 - initial release
// ============================================================================
package keyfifo_pkg;

  // Overflow policy selectors for keycode_event_fifo.OVF_MODE
  localparam int OVF_DROP      = 0;  // full + push: discard the newest event
  localparam int OVF_OVERWRITE = 1;  // full + push: evict the oldest entry

  // Width of the millisecond timestamp carried with each event
  localparam int TS_W = 16;

  // clk27 cycles per millisecond tick
  localparam int MS_PRESCALE = 27000;

endpackage : keyfifo_pkg
`default_nettype wire

// File: rtl/keyfifo_ms_timer.sv
`default_nettype none
// ============================================================================
// Module   : keyfifo_ms_timer
// Brief    : Free-running 1 ms tick prescaler on clk27 plus a wrapping 16-bit
//            millisecond counter used to timestamp keycode events.
// Revision : 1.0 - initial release
// ============================================================================
module keyfifo_ms_timer
  import keyfifo_pkg::*;
(
  input  logic            clk27,
  input  logic            reset_n,
  output logic [TS_W-1:0] ms_count
);

  localparam int                 C_PRE_W    = $clog2(MS_PRESCALE);
  localparam logic [C_PRE_W-1:0] C_PRE_LAST = C_PRE_W'(MS_PRESCALE - 1);

  logic [C_PRE_W-1:0] r_prescale;
  logic [TS_W-1:0]    r_ms;
  logic               w_tick;

  // One tick on the last prescaler count of every millisecond
  assign w_tick = (r_prescale == C_PRE_LAST);

  // Prescaler counts 0..MS_PRESCALE-1; the ms counter wraps naturally at 0xFFFF
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      r_prescale <= '0;
      r_ms       <= '0;
    end else begin
      if (w_tick) begin
        r_prescale <= '0;
        r_ms       <= r_ms + TS_W'(1);
      end else begin
        r_prescale <= r_prescale + C_PRE_W'(1);
      end
    end
  end

  assign ms_count = r_ms;

endmodule : keyfifo_ms_timer
`default_nettype wire

// File: rtl/keycode_event_fifo.sv
`default_nettype none
// ============================================================================
// Module   : keycode_event_fifo
// Brief    : DEPTH-entry show-ahead FIFO of keyboard keycode events in the
//            clk27 domain. The CPU reads the head through PIO and pops it by
//            toggling pop_tgl. Provides occupancy, a sticky overflow flag,
//            a drop-newest / overwrite-oldest overflow policy and the most
//            recently accepted keycode for the legacy PIO field.
// Options  : KEYFIFO_TIMESTAMP_EN - store a millisecond timestamp with every
//            accepted event and present the head's stamp on rd_ts; when not
//            defined rd_ts is tied to 0 and no timer is built.
// Revision : 1.0 - initial release
// ============================================================================
module keycode_event_fifo
  import keyfifo_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 8,
  parameter int OVF_MODE = OVF_DROP
) (
  input  logic                   clk27,
  input  logic                   reset_n,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  input  logic                   pop_tgl,
  input  logic                   flush,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf,
  output logic [DATA_W-1:0]      last_data,
  output logic [TS_W-1:0]        rd_ts
);

  localparam int               C_PTR_W     = $clog2(DEPTH);
  localparam int               C_CNT_W     = C_PTR_W + 1;
  localparam logic [C_CNT_W-1:0] C_FULL_CNT = C_CNT_W'(DEPTH);
  localparam bit               C_OVERWRITE = (OVF_MODE == OVF_OVERWRITE);

  // Storage and bookkeeping state
  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [C_PTR_W-1:0] r_wr_ptr;
  logic [C_PTR_W-1:0] r_rd_ptr;
  logic [C_CNT_W-1:0] r_count;
  logic               r_ovf;
  logic [DATA_W-1:0]  r_last;
  logic               r_pop_prev;

  // Per-cycle decisions
  logic w_pop_ev;
  logic w_empty;
  logic w_full;
  logic w_pop_ok;
  logic w_wr_en;
  logic w_rd_adv;
  logic w_ovf_set;

  // Decode this cycle's push/pop/flush into pointer and flag actions
  always_comb begin
    w_pop_ev  = pop_tgl ^ r_pop_prev;
    w_empty   = (r_count == '0);
    w_full    = (r_count == C_FULL_CNT);
    // A pop on an empty FIFO is silently ignored
    w_pop_ok  = w_pop_ev && !w_empty;
    // Writes succeed unless full with no pop to free a slot, except that the
    // overwrite policy always accepts by evicting the oldest entry
    w_wr_en   = in_valid && !flush && (!w_full || w_pop_ok || C_OVERWRITE);
    // The head advances on a real pop or on an overwrite eviction
    w_rd_adv  = !flush && (w_pop_ok || (in_valid && w_full && C_OVERWRITE));
    // Overflow only when a push meets a full FIFO with no simultaneous pop
    w_ovf_set = !flush && in_valid && w_full && !w_pop_ok;
  end

  // Pointers, occupancy, overflow flag, last accepted keycode and pop edge history
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_last     <= '0;
      r_pop_prev <= 1'b0;
    end else begin
      r_pop_prev <= pop_tgl;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_ovf    <= 1'b0;
      end else begin
        if (w_wr_en) begin
          r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
          r_last   <= in_data;
        end
        if (w_rd_adv) begin
          r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
        end
        if (w_wr_en && !w_rd_adv) begin
          r_count <= r_count + C_CNT_W'(1);
        end else if (!w_wr_en && w_rd_adv) begin
          r_count <= r_count - C_CNT_W'(1);
        end
        if (w_ovf_set) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  // Keycode storage; contents are deliberately not reset
  always_ff @(posedge clk27) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // Show-ahead read port: head entry while non-empty, zero otherwise
  assign rd_data   = w_empty ? '0 : r_mem[r_rd_ptr];
  assign rd_valid  = !w_empty;
  assign count     = r_count;
  assign ovf       = r_ovf;
  assign last_data = r_last;

`ifdef KEYFIFO_TIMESTAMP_EN
  logic [TS_W-1:0] w_ms;
  logic [TS_W-1:0] r_ts_mem [DEPTH];

  keyfifo_ms_timer u_ms_timer (
    .clk27    (clk27),
    .reset_n  (reset_n),
    .ms_count (w_ms)
  );

  // Timestamp array written alongside the keycode array
  always_ff @(posedge clk27) begin
    if (w_wr_en) begin
      r_ts_mem[r_wr_ptr] <= w_ms;
    end
  end

  assign rd_ts = w_empty ? '0 : r_ts_mem[r_rd_ptr];
`else
  assign rd_ts = '0;
`endif

endmodule : keycode_event_fifo
`default_nettype wire

// File: tb/tb_keycode_event_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_keycode_event_fifo
// Brief    : Self-checking bench for keycode_event_fifo. Two instances (drop
//            and overwrite policy) share one stimulus stream and are compared
//            against queue-based reference models each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keycode_event_fifo;
  import keyfifo_pkg::*;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  typedef logic [DATA_W-1:0] kq_t [$];

  logic              clk27 = 1'b0;
  logic              reset_n;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              pop_tgl;
  logic              flush;

  logic [DATA_W-1:0] d0_rd_data, d1_rd_data, d0_last, d1_last;
  logic              d0_rd_valid, d1_rd_valid, d0_ovf, d1_ovf;
  logic [CNT_W-1:0]  d0_count, d1_count;
  logic [TS_W-1:0]   d0_rd_ts, d1_rd_ts;

  always #5 clk27 = ~clk27;

  keycode_event_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OVF_MODE(OVF_DROP)) u_dut_drop (
    .clk27(clk27), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .pop_tgl(pop_tgl), .flush(flush), .rd_data(d0_rd_data), .rd_valid(d0_rd_valid),
    .count(d0_count), .ovf(d0_ovf), .last_data(d0_last), .rd_ts(d0_rd_ts)
  );

  keycode_event_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OVF_MODE(OVF_OVERWRITE)) u_dut_ovw (
    .clk27(clk27), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .pop_tgl(pop_tgl), .flush(flush), .rd_data(d1_rd_data), .rd_valid(d1_rd_valid),
    .count(d1_count), .ovf(d1_ovf), .last_data(d1_last), .rd_ts(d1_rd_ts)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: one queue per policy, plus the pop level history
  kq_t               q0, q1;
  bit                ov0, ov1;
  logic [DATA_W-1:0] last0, last1;
  bit                prev_m;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Queue-level model of one FIFO for one clock edge
  task automatic model_upd(input bit overwrite, inout kq_t q, inout bit ov,
                           inout logic [DATA_W-1:0] last, input bit push,
                           input logic [DATA_W-1:0] d, input bit ev, input bit fl);
    bit popok;
    if (fl) begin
      q.delete();
      ov = 1'b0;
    end else begin
      popok = ev && (q.size() > 0);
      if (push) begin
        if (q.size() < DEPTH || popok) begin
          if (popok) void'(q.pop_front());
          q.push_back(d);
          last = d;
        end else if (overwrite) begin
          void'(q.pop_front());
          q.push_back(d);
          last = d;
          ov   = 1'b1;
        end else begin
          ov = 1'b1;
        end
      end else if (popok) begin
        void'(q.pop_front());
      end
    end
  endtask

  task automatic check_dut(input string p, input kq_t q, input bit ov, input logic [DATA_W-1:0] last,
                           input logic rv, input logic [DATA_W-1:0] rd, input logic [CNT_W-1:0] cnt,
                           input logic o, input logic [DATA_W-1:0] ld, input logic [TS_W-1:0] ts);
    check_val({p, " rd_valid"}, 32'(rv), 32'(q.size() > 0));
    check_val({p, " rd_data"}, 32'(rd), (q.size() > 0) ? 32'(q[0]) : 32'd0);
    check_val({p, " count"}, 32'(cnt), 32'(q.size()));
    check_val({p, " ovf"}, 32'(o), 32'(ov));
    check_val({p, " last_data"}, 32'(ld), 32'(last));
`ifndef KEYFIFO_TIMESTAMP_EN
    check_val({p, " rd_ts"}, 32'(ts), 32'd0);
`else
    if (q.size() == 0) check_val({p, " rd_ts empty"}, 32'(ts), 32'd0);
`endif
  endtask

  task automatic check_all();
    check_dut("drop", q0, ov0, last0, d0_rd_valid, d0_rd_data, d0_count, d0_ovf, d0_last, d0_rd_ts);
    check_dut("ovw",  q1, ov1, last1, d1_rd_valid, d1_rd_data, d1_count, d1_ovf, d1_last, d1_rd_ts);
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete();
    ov0 = 1'b0; ov1 = 1'b0;
    last0 = '0; last1 = '0;
    prev_m = 1'b0;
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge
  task automatic step(input bit push, input logic [DATA_W-1:0] d, input bit pop_lvl, input bit fl);
    bit ev;
    in_valid = push;
    in_data  = d;
    pop_tgl  = pop_lvl;
    flush    = fl;
    @(posedge clk27);
    ev     = pop_lvl ^ prev_m;
    prev_m = pop_lvl;
    model_upd(1'b0, q0, ov0, last0, push, d, ev, fl);
    model_upd(1'b1, q1, ov1, last1, push, d, ev, fl);
    @(negedge clk27);
    in_valid = 1'b0;
    flush    = 1'b0;
    check_all();
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    step(1'b1, d, pop_tgl, 1'b0);
  endtask

  task automatic toggle();
    step(1'b0, '0, ~pop_tgl, 1'b0);
  endtask

  task automatic do_flush();
    step(1'b0, '0, pop_tgl, 1'b1);
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    pop_tgl  = 1'b0;
    flush    = 1'b0;
    model_reset();
    repeat (3) @(negedge clk27);
    check_all();
    reset_n = 1'b1;

    // Two pushes then one pop
    push(16'h1234);
    push(16'h5678);
    check_val("two pushes count", 32'(d0_count), 32'd2);
    check_val("two pushes head", 32'(d0_rd_data), 32'h1234);
    toggle();
    check_val("after pop head", 32'(d0_rd_data), 32'h5678);
    check_val("after pop last", 32'(d0_last), 32'h5678);

    // Overflow under both policies
    do_flush();
    for (int i = 1; i <= 9; i++) push(16'(i));
    check_val("drop full count", 32'(d0_count), 32'd8);
    check_val("drop ovf", 32'(d0_ovf), 32'd1);
    check_val("drop head", 32'(d0_rd_data), 32'h0001);
    check_val("drop last", 32'(d0_last), 32'h0008);
    check_val("ovw head", 32'(d1_rd_data), 32'h0002);
    check_val("ovw last", 32'(d1_last), 32'h0009);
    for (int i = 0; i < 8; i++) toggle();
    check_val("drained rd_valid", 32'(d0_rd_valid), 32'd0);

    // Full with simultaneous push and pop: accepted, no overflow
    do_flush();
    for (int i = 1; i <= 8; i++) push(16'(16'h10 + i));
    step(1'b1, 16'h00AA, ~pop_tgl, 1'b0);
    check_val("full push+pop ovf", 32'(d0_ovf), 32'd0);
    check_val("full push+pop head", 32'(d0_rd_data), 32'h0012);
    for (int i = 0; i < 7; i++) toggle();
    check_val("AA is tail", 32'(d0_rd_data), 32'h00AA);

    // Empty pop, then flush that swallows a push
    do_flush();
    toggle();
    step(1'b1, 16'h0BAD, pop_tgl, 1'b1);
    check_val("flush+push count", 32'(d0_count), 32'd0);
    // Empty with push and pop together: push wins
    step(1'b1, 16'h0C0C, ~pop_tgl, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 99) < 60, 16'($urandom), ($urandom_range(0, 99) < 40) ? ~pop_tgl : pop_tgl,
           $urandom_range(0, 99) < 3);
    end

    // Asynchronous reset mid-operation, pop_tgl held high through reset
    for (int i = 0; i < 4; i++) push(16'($urandom));
    pop_tgl = 1'b1;
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk27);
    reset_n = 1'b1;
    // First cycle sees a pop edge on an empty FIFO; the push still lands
    push(16'h4242);
    push(16'h4343);

`ifdef KEYFIFO_TIMESTAMP_EN
    do_flush();
    repeat (54010) @(negedge clk27);
    push(16'h7777);
    check_val("timestamp 2ms", 32'(d0_rd_ts), 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_keycode_event_fifo
`default_nettype wire
